// File: rtl/puf_measure_ctrl.sv
// Sequencer for one RO-PUF pair of edge counters: clear, count window, wait for both
// done pulses, settle, then compare and shift one response bit per challenge pair.
module puf_measure_ctrl #(
    parameter int NUM_BITS   = 32,
    parameter int CNT_W      = 32,
    parameter int WINDOW     = 1024,
    parameter int CLR_CYC    = 4,
    parameter int SETTLE_CYC = 4,
    parameter int TIMEOUT    = 64,
    localparam int IDX_W     = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic [IDX_W-1:0]    pair_idx,
    output logic                ro_en,
    output logic                cnt_clear,
    output logic                cnt_ctrl,
    input  logic                cnt_done_a,
    input  logic                cnt_done_b,
    input  logic [CNT_W-1:0]    cnt_a,
    input  logic [CNT_W-1:0]    cnt_b,
    output logic                busy,
    output logic                valid,
    output logic                err,
    output logic [7:0]          tie_cnt,
    output logic [NUM_BITS-1:0] response
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_COUNT, S_WAIT, S_SETTLE, S_COMPARE, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         cyc_q, cyc_d;
    logic                done_a_q, done_a_d, done_b_q, done_b_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_BITS-1:0] resp_q, resp_d;
    logic [7:0]          tie_q, tie_d;
    logic                err_q, err_d, valid_q, valid_d;
    logic                ro_en_q, ro_en_d, clr_q, clr_d, ctrl_q, ctrl_d, busy_q, busy_d;
    logic                got_a, got_b;

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q + 32'd1;
        done_a_d = done_a_q;
        done_b_d = done_b_q;
        idx_d    = idx_q;
        resp_d   = resp_q;
        tie_d    = tie_q;
        err_d    = err_q;
        valid_d  = valid_q;
        got_a    = done_a_q | cnt_done_a;
        got_b    = done_b_q | cnt_done_b;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    cyc_d   = '0;
                    resp_d  = '0;
                    tie_d   = '0;
                    err_d   = 1'b0;
                    valid_d = 1'b0;
                    idx_d   = '0;
                end
            end
            S_CLEAR: begin
                if (cyc_q == 32'(CLR_CYC - 1)) begin
                    state_d  = S_COUNT;
                    cyc_d    = '0;
                    done_a_d = 1'b0;
                    done_b_d = 1'b0;
                end
            end
            S_COUNT: begin
                if (cyc_q == 32'(WINDOW - 1)) begin
                    state_d = S_WAIT;
                    cyc_d   = '0;
                end
            end
            S_WAIT: begin
                // Done pulses arrive from slow RO domains, possibly far apart.
                done_a_d = got_a;
                done_b_d = got_b;
                if (got_a && got_b) begin
                    state_d = S_SETTLE;
                    cyc_d   = '0;
                end else if (cyc_q == 32'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    resp_d  = '0;
                end
            end
            S_SETTLE: begin
                if (cyc_q == 32'(SETTLE_CYC - 1)) begin
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                resp_d[idx_q] = (cnt_a > cnt_b);
                if ((cnt_a == cnt_b) && (tie_q != 8'hFF)) begin
                    tie_d = tie_q + 8'd1;
                end
                if (idx_q == IDX_W'(NUM_BITS - 1)) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_CLEAR;
                    cyc_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            resp_d  = '0;
            idx_d   = '0;
        end

        // Control outputs are decoded from the next state so they register in step with it.
        ro_en_d = (state_d == S_CLEAR) || (state_d == S_COUNT) || (state_d == S_WAIT);
        clr_d   = (state_d == S_CLEAR);
        ctrl_d  = (state_d == S_COUNT);
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
            idx_q    <= '0;
            resp_q   <= '0;
            tie_q    <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            ro_en_q  <= 1'b0;
            clr_q    <= 1'b0;
            ctrl_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            done_a_q <= done_a_d;
            done_b_q <= done_b_d;
            idx_q    <= idx_d;
            resp_q   <= resp_d;
            tie_q    <= tie_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            ro_en_q  <= ro_en_d;
            clr_q    <= clr_d;
            ctrl_q   <= ctrl_d;
            busy_q   <= busy_d;
        end
    end

    assign pair_idx  = idx_q;
    assign ro_en     = ro_en_q;
    assign cnt_clear = clr_q;
    assign cnt_ctrl  = ctrl_q;
    assign busy      = busy_q;
    assign valid     = valid_q;
    assign err       = err_q;
    assign tie_cnt   = tie_q;
    assign response  = resp_q;

endmodule

// File: tb/tb_puf_measure_ctrl.sv
// Bench for puf_measure_ctrl: a counter-pair responder plus a run-level scoreboard.
module tb_puf_measure_ctrl;

    localparam int NB  = 256;
    localparam int CW  = 32;
    localparam int WIN = 16;
    localparam int CLR = 4;
    localparam int SET = 4;
    localparam int TO  = 64;
    localparam int BUDGET = 20000;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [7:0]    pair_idx;
    logic          ro_en, cnt_clear, cnt_ctrl, busy, valid, err;
    logic          cnt_done_a, cnt_done_b;
    logic [CW-1:0] cnt_a, cnt_b;
    logic [7:0]    tie_cnt;
    logic [NB-1:0] response;

    logic [CW-1:0] tbl_a [NB];
    logic [CW-1:0] tbl_b [NB];

    int da_cfg = 1;
    int db_cfg = 1;
    int sup_b  = -1;
    int spur_req = 0;
    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [NB-1:0] resp;
        logic [7:0]    tie;
        logic          err;
        logic          valid;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    puf_measure_ctrl #(
        .NUM_BITS(NB), .CNT_W(CW), .WINDOW(WIN), .CLR_CYC(CLR),
        .SETTLE_CYC(SET), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pair_idx(pair_idx), .ro_en(ro_en), .cnt_clear(cnt_clear), .cnt_ctrl(cnt_ctrl),
        .cnt_done_a(cnt_done_a), .cnt_done_b(cnt_done_b), .cnt_a(cnt_a), .cnt_b(cnt_b),
        .busy(busy), .valid(valid), .err(err), .tie_cnt(tie_cnt), .response(response)
    );

    task automatic check_val(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int upto, input bit tmo);
        exp_t r;
        r.resp = '0;
        r.tie  = '0;
        for (int i = 0; i < upto; i++) begin
            if (tbl_a[i] > tbl_b[i]) r.resp[i] = 1'b1;
            else if (tbl_a[i] == tbl_b[i] && r.tie != 8'hFF) r.tie = r.tie + 8'd1;
        end
        if (tmo) begin
            r.resp  = '0;
            r.err   = 1'b1;
            r.valid = 1'b0;
        end else begin
            r.err   = 1'b0;
            r.valid = 1'b1;
        end
        return r;
    endfunction

    task automatic fill_nominal();
        for (int i = 0; i < NB; i++) begin
            tbl_a[i] = CW'($urandom_range(0, 7));
            tbl_b[i] = CW'($urandom_range(0, 7));
        end
        tbl_a[0] = 100; tbl_b[0] = 90;
        tbl_a[1] = 50;  tbl_b[1] = 60;
        tbl_a[2] = 70;  tbl_b[2] = 70;
        tbl_a[3] = 70;  tbl_b[3] = 10;
        tbl_a[4] = 32'h8000_0000; tbl_b[4] = 1;
    endtask

    // Models both edge counters: value by pair, done pulses a set delay after the window closes.
    initial begin : responder
        int   dly_a, dly_b, len, spur_ack;
        logic prev_ctrl;
        dly_a = 0; dly_b = 0; len = 0; spur_ack = 0; prev_ctrl = 1'b0;
        cnt_done_a = 1'b0; cnt_done_b = 1'b0; cnt_a = '0; cnt_b = '0;
        forever begin
            @(negedge clk);
            cnt_done_a = (dly_a == 1);
            cnt_done_b = (dly_b == 1);
            if (dly_a > 0) dly_a--;
            if (dly_b > 0) dly_b--;
            if (cnt_done_b && db_cfg > da_cfg) check_val("hold_ro_en", ro_en, 1);
            if (spur_req != spur_ack) begin
                cnt_done_a = 1'b1;
                cnt_done_b = 1'b1;
                spur_ack   = spur_req;
            end
            if (cnt_ctrl) len++;
            else if (prev_ctrl) begin
                if (busy) begin
                    check_val("ctrl_len", len, WIN);
                    dly_a = da_cfg;
                    dly_b = (int'(pair_idx) == sup_b) ? 0 : db_cfg;
                end
                len = 0;
            end
            prev_ctrl = cnt_ctrl;
            cnt_a = tbl_a[pair_idx];
            cnt_b = tbl_b[pair_idx];
        end
    end

    task automatic do_run(input string name, input int bs_at, output int wl);
        exp_t e;
        int   n, cur;
        bit   bs_done;
        logic [7:0] p;
        n = 0; cur = 0; wl = 0; bs_done = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val({name, "_busy"}, busy, 1);
        check_val({name, "_clr"}, {err, valid}, 0);
        check_val({name, "_resp0"}, response, 0);
        while (busy && n < BUDGET) begin
            if (ro_en && !cnt_ctrl && !cnt_clear) cur++;
            else begin
                if (cur != 0) wl = cur;
                cur = 0;
            end
            if (bs_at >= 0 && !bs_done && int'(pair_idx) == bs_at && cnt_ctrl) begin
                p = pair_idx;
                start = 1'b1;
                @(negedge clk);
                n++;
                start = 1'b0;
                check_val({name, "_busy_start_idx"}, pair_idx, p);
                check_val({name, "_busy_start_busy"}, busy, 1);
                bs_done = 1;
            end
            @(negedge clk);
            n++;
        end
        if (cur != 0) wl = cur;
        check_val({name, "_finished"}, (n < BUDGET), 1);
        e = sb_q.pop_front();
        check_val({name, "_response"}, response, e.resp);
        check_val({name, "_tie_cnt"}, tie_cnt, e.tie);
        check_val({name, "_err"}, err, e.err);
        check_val({name, "_valid"}, valid, e.valid);
        check_val({name, "_outs_off"}, {busy, ro_en, cnt_clear, cnt_ctrl}, 0);
        if (e.valid) check_val({name, "_last_idx"}, pair_idx, NB - 1);
        $display("run %s: cycles=%0d resp_lo=%h tie=%0d err=%0b valid=%0b wait=%0d",
                 name, n, response[15:0], tie_cnt, err, valid, wl);
    endtask

    initial begin : main
        int wl, n;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        fill_nominal();
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_outs", {pair_idx, ro_en, cnt_clear, cnt_ctrl, busy, valid, err, tie_cnt}, 0);
        check_val("rst_resp", response, 0);
        rst = 1'b1;
        spur_req++;
        repeat (4) @(negedge clk);
        check_val("spur_idle", {busy, ro_en, cnt_clear, cnt_ctrl, valid}, 0);

        // Asynchronous reset in the middle of a count window.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!cnt_ctrl && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("reach_count", cnt_ctrl, 1);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("async_rst", {pair_idx, ro_en, cnt_clear, cnt_ctrl, busy, valid, err, tie_cnt}, 0);
        check_val("async_rst_resp", response, 0);
        @(negedge clk);
        rst = 1'b1;
        spur_req++;
        repeat (4) @(negedge clk);
        check_val("spur_idle2", {busy, ro_en, valid}, 0);

        // Nominal run, second start while busy at pair 3.
        sb_q.push_back(model(NB, 0));
        do_run("nominal", 3, wl);
        check_val("nom_low4", response[3:0], 4'b1001);
        check_val("nom_unsigned", response[4], 1);
        check_val("nom_wait", wl, 2);

        // Done skew: B arrives five cycles after A.
        fill_nominal();
        db_cfg = 6;
        sb_q.push_back(model(NB, 0));
        do_run("skew", -1, wl);
        check_val("skew_wait", wl, 7);
        db_cfg = 1;

        // Done B missing on pair 2.
        fill_nominal();
        sup_b = 2;
        sb_q.push_back(model(2, 1));
        do_run("timeout", -1, wl);
        check_val("timeout_wait", wl, TO);
        sup_b = -1;
        sb_q.push_back(model(NB, 0));
        do_run("rerun", -1, wl);

        // Abort in count window of pair 1, with a coincident start.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(pair_idx == 8'd1 && cnt_ctrl) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("abort_reach", {pair_idx == 8'd1, cnt_ctrl}, 2'b11);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check_val("abort_outs", {busy, ro_en, cnt_clear, cnt_ctrl, valid}, 0);
        check_val("abort_resp", response, 0);
        repeat (3) @(negedge clk);
        check_val("abort_stay_idle", {busy, ro_en}, 0);
        $display("run abort: busy=%0b resp_lo=%h", busy, response[15:0]);

        // All pairs tie: response zero, tie counter saturates.
        for (int i = 0; i < NB; i++) begin
            tbl_a[i] = CW'(i * 3);
            tbl_b[i] = CW'(i * 3);
        end
        sb_q.push_back(model(NB, 0));
        do_run("ties", -1, wl);
        check_val("ties_sat", tie_cnt, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
